// File: rtl/vis_center_ctrl.sv
// Picks one circle centre per frame from the centroid or manual source and commits it at the vsync edge.
// Latency: all outputs update on the frame-boundary edge only, visible one cycle after vsync goes active.
// Backpressure: one-entry buffer per source; ready stays low until the next frame boundary clears the buffer.
module vis_center_ctrl #(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int CW          = 11,
  parameter int HOLD_FRAMES = 4,
  parameter int VS_POL      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          cen_valid,
  input  logic [CW-1:0] cen_x,
  input  logic [CW-1:0] cen_y,
  output logic          cen_ready,
  input  logic          man_valid,
  input  logic [CW-1:0] man_x,
  input  logic [CW-1:0] man_y,
  output logic          man_ready,
  input  logic          man_mode,
  output logic [CW-1:0] x_center,
  output logic [CW-1:0] y_center,
  output logic          circle_en,
  output logic [1:0]    state,
  output logic [3:0]    miss_cnt
);

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2,
    LOST  = 2'd3
  } state_t;

  localparam logic [CW-1:0] X_MAX    = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_MAX    = CW'(IMG_H - 1);
  localparam logic [3:0]    HOLD_LIM = 4'(HOLD_FRAMES);

  logic   vs_a, vs_q, fb;
  logic   cen_full, man_full;
  coord_t cen_buf, man_buf;
  coord_t win, win_clamp;
  logic   have_cmt, sel_man;

  state_t     state_q, state_d;
  logic [3:0] miss_q, miss_d, miss_inc;
  logic       en_q, en_d;
  coord_t     ctr_q, ctr_d;

  assign vs_a = (VS_POL != 0) ? vsync : ~vsync;
  assign fb   = vs_a & ~vs_q;

  assign cen_ready = ~cen_full;
  assign man_ready = ~man_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      cen_full <= 1'b0;
      man_full <= 1'b0;
      cen_buf  <= '0;
      man_buf  <= '0;
    end else begin
      vs_q <= vs_a;
      // Clear first so a handshake landing on the boundary cycle survives into the next frame.
      if (fb) begin
        cen_full <= 1'b0;
        man_full <= 1'b0;
      end
      if (cen_valid && !cen_full) begin
        cen_full <= 1'b1;
        cen_buf  <= '{x: cen_x, y: cen_y};
      end
      if (man_valid && !man_full) begin
        man_full <= 1'b1;
        man_buf  <= '{x: man_x, y: man_y};
      end
    end
  end

  assign have_cmt    = cen_full | man_full;
  assign sel_man     = man_mode ? man_full : ~cen_full;
  assign win         = sel_man ? man_buf : cen_buf;
  assign win_clamp.x = (win.x > X_MAX) ? X_MAX : win.x;
  assign win_clamp.y = (win.y > Y_MAX) ? Y_MAX : win.y;
  assign miss_inc    = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      miss_q  <= '0;
      en_q    <= 1'b0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      en_q    <= en_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    en_d    = en_q;
    ctr_d   = ctr_q;
    if (fb) begin
      if (have_cmt) begin
        state_d = TRACK;
        miss_d  = '0;
        en_d    = 1'b1;
        ctr_d   = win_clamp;
      end else begin
        case (state_q)
          IDLE: begin
            en_d   = 1'b0;
            miss_d = '0;
          end
          TRACK, HOLD: begin
            miss_d = miss_inc;
            if (miss_inc <= HOLD_LIM) begin
              state_d = HOLD;
              en_d    = 1'b1;
            end else begin
              state_d = LOST;
              en_d    = 1'b0;
            end
          end
          default: begin
            miss_d = miss_inc;
            en_d   = 1'b0;
          end
        endcase
      end
    end
  end

  assign x_center  = ctr_q.x;
  assign y_center  = ctr_q.y;
  assign circle_en = en_q;
  assign state     = state_q;
  assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_vis_center_ctrl.sv
// Directed bench for vis_center_ctrl: inputs change on the falling edge, outputs are checked on the falling edge.
module tb_vis_center_ctrl;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          cen_valid = 1'b0;
  logic [CW-1:0] cen_x = '0;
  logic [CW-1:0] cen_y = '0;
  logic          cen_ready;
  logic          man_valid = 1'b0;
  logic [CW-1:0] man_x = '0;
  logic [CW-1:0] man_y = '0;
  logic          man_ready;
  logic          man_mode = 1'b0;
  logic [CW-1:0] x_center;
  logic [CW-1:0] y_center;
  logic          circle_en;
  logic [1:0]    state;
  logic [3:0]    miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  vis_center_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync),
    .cen_valid(cen_valid), .cen_x(cen_x), .cen_y(cen_y), .cen_ready(cen_ready),
    .man_valid(man_valid), .man_x(man_x), .man_y(man_y), .man_ready(man_ready),
    .man_mode(man_mode),
    .x_center(x_center), .y_center(y_center), .circle_en(circle_en),
    .state(state), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // One-cycle vsync pulse; returns on the falling edge right after the boundary edge.
  task automatic frame();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
  endtask

  task automatic send_cen(input int x, input int y);
    @(negedge clk); cen_valid = 1'b1; cen_x = CW'(x); cen_y = CW'(y);
    @(negedge clk); cen_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
    vectors++; if ({x_center, y_center} !== '0) begin miscompares++; $display("FAIL reset_xy got %0d,%0d exp 0,0", x_center, y_center); end
    vectors++; if ({circle_en, miss_cnt} !== 5'd0) begin miscompares++; $display("FAIL reset_en_miss got %0d,%0d exp 0,0", circle_en, miss_cnt); end
    vectors++; if ({cen_ready, man_ready} !== 2'b11) begin miscompares++; $display("FAIL reset_ready got %b exp 11", {cen_ready, man_ready}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_track();
    send_cen(28, 37);
    vectors++; if (cen_ready !== 1'b0) begin miscompares++; $display("FAIL t1_ready_full got %b exp 0", cen_ready); end
    repeat (3) @(negedge clk);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL t1_pre_fb_state got %0d exp 0", state); end
    frame();
    vectors++; if (x_center !== 11'd28 || y_center !== 11'd37) begin miscompares++; $display("FAIL t1_xy got %0d,%0d exp 28,37", x_center, y_center); end
    vectors++; if (circle_en !== 1'b1 || state !== 2'd1 || miss_cnt !== 4'd0) begin miscompares++; $display("FAIL t1_track got en=%b st=%0d miss=%0d exp 1,1,0", circle_en, state, miss_cnt); end
    vectors++; if (cen_ready !== 1'b1) begin miscompares++; $display("FAIL t1_ready_free got %b exp 1", cen_ready); end
  endtask

  task automatic test_priority();
    man_mode = 1'b1;
    @(negedge clk);
    cen_valid = 1'b1; cen_x = 11'd10; cen_y = 11'd10;
    man_valid = 1'b1; man_x = 11'd50; man_y = 11'd20;
    @(negedge clk);
    cen_valid = 1'b0; man_valid = 1'b0;
    vectors++; if ({cen_ready, man_ready} !== 2'b00) begin miscompares++; $display("FAIL t2_both_accepted got %b exp 00", {cen_ready, man_ready}); end
    frame();
    vectors++; if (x_center !== 11'd50 || y_center !== 11'd20) begin miscompares++; $display("FAIL t2_man_wins got %0d,%0d exp 50,20", x_center, y_center); end
    vectors++; if ({cen_ready, man_ready} !== 2'b11) begin miscompares++; $display("FAIL t2_loser_dropped got %b exp 11", {cen_ready, man_ready}); end
    repeat (3) @(negedge clk);
    frame();
    vectors++; if (state !== 2'd2 || miss_cnt !== 4'd1 || circle_en !== 1'b1) begin miscompares++; $display("FAIL t2_hold got st=%0d miss=%0d en=%b exp 2,1,1", state, miss_cnt, circle_en); end
    vectors++; if (x_center !== 11'd50 || y_center !== 11'd20) begin miscompares++; $display("FAIL t2_hold_xy got %0d,%0d exp 50,20", x_center, y_center); end
    man_mode = 1'b0;
  endtask

  task automatic test_hold_lost();
    send_cen(30, 31);
    frame();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL t3_track got %0d exp 1", state); end
    for (int i = 1; i <= 16; i++) begin
      repeat (2) @(negedge clk);
      frame();
      vectors++;
      if (i <= 4) begin
        if (state !== 2'd2 || circle_en !== 1'b1 || miss_cnt !== 4'(i)) begin miscompares++; $display("FAIL t3_hold_%0d got st=%0d en=%b miss=%0d exp 2,1,%0d", i, state, circle_en, miss_cnt, i); end
      end else if (i == 5) begin
        if (state !== 2'd3 || circle_en !== 1'b0 || miss_cnt !== 4'd5 || x_center !== 11'd30 || y_center !== 11'd31) begin miscompares++; $display("FAIL t3_lost got st=%0d en=%b miss=%0d xy=%0d,%0d exp 3,0,5,30,31", state, circle_en, miss_cnt, x_center, y_center); end
      end else begin
        if (state !== 2'd3 || circle_en !== 1'b0 || miss_cnt !== 4'((i > 15) ? 15 : i)) begin miscompares++; $display("FAIL t3_lost_%0d got st=%0d en=%b miss=%0d", i, state, circle_en, miss_cnt); end
      end
    end
    send_cen(5, 6);
    frame();
    vectors++; if (state !== 2'd1 || circle_en !== 1'b1 || miss_cnt !== 4'd0) begin miscompares++; $display("FAIL t3_reacquire got st=%0d en=%b miss=%0d exp 1,1,0", state, circle_en, miss_cnt); end
    vectors++; if (x_center !== 11'd5 || y_center !== 11'd6) begin miscompares++; $display("FAIL t3_reacquire_xy got %0d,%0d exp 5,6", x_center, y_center); end
  endtask

  task automatic test_clamp();
    send_cen(100, 70);
    frame();
    vectors++; if (x_center !== 11'd63 || y_center !== 11'd63) begin miscompares++; $display("FAIL t4_clamp got %0d,%0d exp 63,63", x_center, y_center); end
    send_cen(62, 64);
    frame();
    vectors++; if (x_center !== 11'd62 || y_center !== 11'd63) begin miscompares++; $display("FAIL t4_clamp_y got %0d,%0d exp 62,63", x_center, y_center); end
    send_cen(63, 63);
    frame();
    vectors++; if (x_center !== 11'd63 || y_center !== 11'd63) begin miscompares++; $display("FAIL t4_edge got %0d,%0d exp 63,63", x_center, y_center); end
  endtask

  task automatic test_fb_handshake();
    @(negedge clk);
    vsync = 1'b1; cen_valid = 1'b1; cen_x = 11'd7; cen_y = 11'd8;
    @(negedge clk);
    vsync = 1'b0; cen_valid = 1'b0;
    vectors++; if (state !== 2'd2 || x_center !== 11'd63 || y_center !== 11'd63) begin miscompares++; $display("FAIL t5_not_used got st=%0d xy=%0d,%0d exp 2,63,63", state, x_center, y_center); end
    repeat (5) @(negedge clk);
    vectors++; if (cen_ready !== 1'b0) begin miscompares++; $display("FAIL t5_ready_low got %b exp 0", cen_ready); end
    frame();
    vectors++; if (x_center !== 11'd7 || y_center !== 11'd8 || state !== 2'd1) begin miscompares++; $display("FAIL t5_commit got %0d,%0d st=%0d exp 7,8,1", x_center, y_center, state); end
    vectors++; if (cen_ready !== 1'b1) begin miscompares++; $display("FAIL t5_ready_free got %b exp 1", cen_ready); end
  endtask

  task automatic test_long_vsync();
    @(negedge clk); vsync = 1'b1;
    repeat (3) @(negedge clk);
    man_valid = 1'b1; man_x = 11'd40; man_y = 11'd41;
    @(negedge clk); man_valid = 1'b0;
    repeat (15) @(negedge clk);
    vectors++; if (miss_cnt !== 4'd1 || state !== 2'd2) begin miscompares++; $display("FAIL t7_single_fb got miss=%0d st=%0d exp 1,2", miss_cnt, state); end
    vectors++; if (x_center !== 11'd7 || man_ready !== 1'b0) begin miscompares++; $display("FAIL t7_held got x=%0d mrdy=%b exp 7,0", x_center, man_ready); end
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    frame();
    vectors++; if (x_center !== 11'd40 || y_center !== 11'd41 || state !== 2'd1) begin miscompares++; $display("FAIL t7_commit got %0d,%0d st=%0d exp 40,41,1", x_center, y_center, state); end
  endtask

  task automatic test_reset_midframe();
    send_cen(11, 12);
    vectors++; if (cen_ready !== 1'b0 || state !== 2'd1) begin miscompares++; $display("FAIL t6_pre got rdy=%b st=%0d exp 0,1", cen_ready, state); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (state !== 2'd0 || circle_en !== 1'b0 || x_center !== '0 || y_center !== '0) begin miscompares++; $display("FAIL t6_async got st=%0d en=%b xy=%0d,%0d exp 0,0,0,0", state, circle_en, x_center, y_center); end
    vectors++; if ({cen_ready, man_ready} !== 2'b11) begin miscompares++; $display("FAIL t6_ready got %b exp 11", {cen_ready, man_ready}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame();
    vectors++; if (state !== 2'd0 || circle_en !== 1'b0 || miss_cnt !== 4'd0 || x_center !== '0) begin miscompares++; $display("FAIL t6_idle got st=%0d en=%b miss=%0d x=%0d exp 0,0,0,0", state, circle_en, miss_cnt, x_center); end
  endtask

  initial begin
    test_reset();
    test_track();
    test_priority();
    test_hold_lost();
    test_clamp();
    test_fb_handshake();
    test_long_vsync();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
